// File: rtl/seq_check.sv
// Serial bit-pattern detector: pulses ind for one cycle when the last PAT_LEN
// sampled bits equal PATTERN (earliest bit in the MSB).
module seq_check #(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
    parameter bit                   OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic ind
);

    localparam int unsigned CNT_W = $clog2(PAT_LEN + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(PAT_LEN);

    logic [PAT_LEN-1:0] history_q, history_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic               ind_q, ind_d;
    logic               match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
            ind_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            ind_q     <= ind_d;
        end
    end

    // Match is judged on next-state values so ind rises on the edge that
    // samples the final pattern bit; the fill count hides reset-zero history.
    always_comb begin
        history_d = {history_q[PAT_LEN-2:0], data};
        fill_d    = (fill_q == FULL) ? fill_q : fill_q + CNT_W'(1);
        match     = (history_d == PATTERN) && (fill_d == FULL);
        ind_d     = match;
        if (match && !OVERLAP) begin
            history_d = '0;
            fill_d    = '0;
        end
    end

    assign ind = ind_q;

endmodule

// File: tb/tb_seq_check.sv
// Directed bench for seq_check: four parameterisations driven side by side,
// expected ind values queued per step and checked after each rising edge.
module tb_seq_check;

    logic clk;
    logic rst;
    logic data_m, data_z, data_o;
    logic ind_a, ind_b, ind_z, ind_o;

    int tests = 0;
    int fails = 0;
    string grp = "reset";
    int step_no = 0;
    logic [3:0] sb[$];

    seq_check u_a (.clk(clk), .rst(rst), .data(data_m), .ind(ind_a));
    seq_check #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .data(data_m), .ind(ind_b));
    seq_check #(.PAT_LEN(3), .PATTERN(3'b000), .OVERLAP(1'b1))
        u_z (.clk(clk), .rst(rst), .data(data_z), .ind(ind_z));
    seq_check #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1))
        u_o (.clk(clk), .rst(rst), .data(data_o), .ind(ind_o));

    // Rising edges at 10, 20, 30 ... ns; falling edges at 5, 15, 25 ... ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        for (int i = 3; i >= 0; i--) begin
            tests++;
            assert (obs[i] === exp[i]) else begin
                fails++;
                $error("FAIL %s step %0d inst %0d: ind observed %b, expected %b",
                       tag, step_no, 3 - i, obs[i], exp[i]);
            end
        end
    endtask

    // Drive one bit per instance, queue expectations, check after the edge.
    task automatic step(input logic dm, input logic dz, input logic d_o, input logic [3:0] e);
        logic [3:0] exp;
        data_m = dm;
        data_z = dz;
        data_o = d_o;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        @(negedge clk);
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL %s scoreboard empty: observed size 0, expected >0", grp);
        end
        exp = sb.pop_front();
        cmp(grp, {ind_a, ind_b, ind_z, ind_o}, exp);
        #2;
    endtask

    // Run an MSB-first stream on the 1011 pair; other instances held idle.
    task automatic run(input string g, input logic [31:0] bits, input int n,
                       input logic [31:0] ea, input logic [31:0] eb);
        grp = g;
        step_no = 0;
        for (int i = 0; i < n; i++)
            step(bits[n-1-i], 1'b1, 1'b0, {ea[n-1-i], eb[n-1-i], 1'b0, 1'b0});
    endtask

    // Reset asserted between edges must clear ind without a clock.
    task automatic reset_pulse(input string g);
        #1 rst = 1'b1;
        #1 cmp({g, "_async_rst"}, {ind_a, ind_b, ind_z, ind_o}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #2;
    endtask

    initial begin
        rst = 1'b1;
        data_m = 1'bx;
        data_z = 1'bx;
        data_o = 1'bx;
        #12 cmp("reset_hold", {ind_a, ind_b, ind_z, ind_o}, 4'b0000);
        #3 rst = 1'b0;
        #2;

        run("reference", 32'b0011011011110110000, 19,
            32'b0000001001000010000, 32'b0000001000000010000);
        reset_pulse("ref");

        run("overlap", 32'b1011011, 7, 32'b0001001, 32'b0001000);
        reset_pulse("overlap");

        run("near_miss_101011", 32'b101011, 6, 32'b000001, 32'b000001);
        reset_pulse("nm1");
        run("near_miss_10011", 32'b10011, 5, 32'b00000, 32'b00000);
        reset_pulse("nm2");
        run("near_miss_1111", 32'b1111, 4, 32'b0000, 32'b0000);
        reset_pulse("nm3");

        run("mid_pre", 32'b101, 3, 32'b000, 32'b000);
        reset_pulse("mid");
        run("mid_post", 32'b1011, 4, 32'b0001, 32'b0001);
        reset_pulse("mid2");

        // PAT_LEN=3, all-zero pattern: fill count gates the first two edges.
        grp = "zeros";
        step_no = 0;
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0010);
        reset_pulse("zeros");

        // PAT_LEN=2, pattern 11: back-to-back pulses on a run of ones.
        grp = "ones";
        step_no = 0;
        step(1'b0, 1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b0001);
        reset_pulse("ones");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
